pipe_stage_reg: RTL and testbench

- Generic parametrised inter-stage pipeline register for the MIPS pipeline (D/E, E/M, M/W slots), one instance per boundary.
- Carries PC, IR, control word and N data lanes, plus valid, exception code and branch-delay (BD) flag.
- Adds stall (hold), two flush modes (full bubble, bubble keeping PC/BD), earliest-exception merge and a saturating stall-cycle counter.

---
 rtl/pipe_stage_reg_pkg.sv | 15 +
 rtl/pipe_lane_reg.sv | 38 +++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers.
package pipe_stage_reg_pkg;

  typedef enum logic [4:0] {
    EXC_NONE    = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] PC_RST_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pipe_lane_reg.sv
// One W-bit pipeline field: synchronous reset, clear to the reset value, hold, or load.
module pipe_lane_reg #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_d;
  logic [W-1:0] val_q = RST_VAL;

  // Next value: clear beats hold, hold beats load.
  always_comb begin
    val_d = val_q;
    if (clear) begin
      val_d = RST_VAL;
    end else if (!hold) begin
      val_d = d;
    end
  end

  // Field register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage register (D/E, E/M, M/W) with stall, two flush
// flavours, earliest-exception merge and a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          W      = 32,
  parameter int          NLANES = 3,
  parameter int          EXC_W  = 5,
  parameter logic [31:0] PC_RST = PC_RST_DEFAULT,
  parameter int          CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  flush_keep_pc,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_pc,
  input  logic [W-1:0]          in_ir,
  input  logic [W-1:0]          in_ctrl,
  input  logic [NLANES*W-1:0]   in_data,
  input  logic [EXC_W-1:0]      in_exc,
  input  logic [EXC_W-1:0]      in_exc_new,
  input  logic                  in_bd,
  output logic                  out_valid,
  output logic [W-1:0]          out_pc,
  output logic [W-1:0]          out_ir,
  output logic [W-1:0]          out_ctrl,
  output logic [NLANES*W-1:0]   out_data,
  output logic [EXC_W-1:0]      out_exc,
  output logic                  out_bd,
  output logic [CNT_W-1:0]      stall_cnt
);

  if (NLANES < 1) begin : g_bad_nlanes
    $error("pipe_stage_reg: NLANES must be at least 1");
  end

  // Either flush turns the slot into a bubble; only the full flush resets PC/BD.
  logic any_flush;
  logic pc_clear;
  logic pc_hold;
  assign any_flush = flush | flush_keep_pc;
  assign pc_clear  = flush;
  assign pc_hold   = stall & ~flush_keep_pc;

  pipe_lane_reg #(.W(W), .RST_VAL(W'(PC_RST))) u_pc (
    .clk(clk), .reset(reset), .hold(pc_hold), .clear(pc_clear),
    .d(in_pc), .q(out_pc)
  );

  pipe_lane_reg #(.W(W), .RST_VAL('0)) u_ir (
    .clk(clk), .reset(reset), .hold(stall), .clear(any_flush),
    .d(in_ir), .q(out_ir)
  );

  pipe_lane_reg #(.W(W), .RST_VAL('0)) u_ctrl (
    .clk(clk), .reset(reset), .hold(stall), .clear(any_flush),
    .d(in_ctrl), .q(out_ctrl)
  );

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    pipe_lane_reg #(.W(W), .RST_VAL('0)) u_lane (
      .clk(clk), .reset(reset), .hold(stall), .clear(any_flush),
      .d(in_data[k*W +: W]), .q(out_data[k*W +: W])
    );
  end

  logic             valid_d, valid_q = 1'b0;
  logic [EXC_W-1:0] exc_d,   exc_q   = '0;
  logic             bd_d,    bd_q    = 1'b0;
  logic [CNT_W-1:0] cnt_d,   cnt_q   = '0;

  // Next-state for valid, merged exception, BD flag and stall counter.
  always_comb begin
    valid_d = valid_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      exc_d   = '0;
      bd_d    = 1'b0;
    end else if (flush_keep_pc) begin
      valid_d = 1'b0;
      exc_d   = '0;
      bd_d    = in_bd;
    end else if (stall) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d = in_valid;
      exc_d   = (in_exc != EXC_W'(EXC_NONE)) ? in_exc : in_exc_new;
      bd_d    = in_bd;
    end
  end

  // Control-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_exc   = exc_q;
  assign out_bd    = bd_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: default instance plus a CNT_W=2, NLANES=1 instance,
// checked each cycle against a behavioural model and at directed points.
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, stall, flush, flush_keep_pc, in_valid, in_bd;
  logic [W-1:0]   in_pc, in_ir, in_ctrl;
  logic [3*W-1:0] in_data;
  logic [4:0]     in_exc, in_exc_new;

  logic           out_valid, out_bd;
  logic [W-1:0]   out_pc, out_ir, out_ctrl;
  logic [3*W-1:0] out_data;
  logic [4:0]     out_exc;
  logic [15:0]    stall_cnt;

  logic           out_valid2, out_bd2;
  logic [W-1:0]   out_pc2, out_ir2, out_ctrl2, out_data2;
  logic [4:0]     out_exc2;
  logic [1:0]     stall_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .flush_keep_pc(flush_keep_pc), .in_valid(in_valid), .in_pc(in_pc),
    .in_ir(in_ir), .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc),
    .in_exc_new(in_exc_new), .in_bd(in_bd), .out_valid(out_valid),
    .out_pc(out_pc), .out_ir(out_ir), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_exc(out_exc), .out_bd(out_bd),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.NLANES(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .flush_keep_pc(flush_keep_pc), .in_valid(in_valid), .in_pc(in_pc),
    .in_ir(in_ir), .in_ctrl(in_ctrl), .in_data(in_data[W-1:0]), .in_exc(in_exc),
    .in_exc_new(in_exc_new), .in_bd(in_bd), .out_valid(out_valid2),
    .out_pc(out_pc2), .out_ir(out_ir2), .out_ctrl(out_ctrl2),
    .out_data(out_data2), .out_exc(out_exc2), .out_bd(out_bd2),
    .stall_cnt(stall_cnt2)
  );

  // Behavioural model of the slot contents, starting at power-up values.
  logic           m_valid = 1'b0;
  logic [W-1:0]   m_pc    = 32'h0000_3000;
  logic [W-1:0]   m_ir    = '0;
  logic [W-1:0]   m_ctrl  = '0;
  logic [3*W-1:0] m_data  = '0;
  logic [4:0]     m_exc   = '0;
  logic           m_bd    = 1'b0;
  int             m_cnt   = 0;
  int             m_cnt2  = 0;

  // Model update from the priority rules: reset, flush, flush_keep_pc, stall, load.
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_pc = 32'h3000; m_ir = 0; m_ctrl = 0; m_data = 0;
      m_exc = 0; m_bd = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (flush || flush_keep_pc) begin
      m_valid = 0; m_ir = 0; m_ctrl = 0; m_data = 0; m_exc = 0;
      m_pc = flush ? 32'h3000 : in_pc;
      m_bd = flush ? 1'b0 : in_bd;
    end else if (stall) begin
      m_cnt  = (m_cnt  + 1 > 65535) ? 65535 : m_cnt + 1;
      m_cnt2 = (m_cnt2 + 1 > 3)     ? 3     : m_cnt2 + 1;
    end else begin
      m_valid = in_valid; m_pc = in_pc; m_ir = in_ir; m_ctrl = in_ctrl;
      m_data = in_data; m_bd = in_bd;
      m_exc = (in_exc != 0) ? in_exc : in_exc_new;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("valid",  out_valid, m_valid);
    checkOutput("pc",     out_pc,    m_pc);
    checkOutput("ir",     out_ir,    m_ir);
    checkOutput("ctrl",   out_ctrl,  m_ctrl);
    checkOutput("data",   out_data,  m_data);
    checkOutput("exc",    out_exc,   m_exc);
    checkOutput("bd",     out_bd,    m_bd);
    checkOutput("cnt",    stall_cnt, m_cnt[15:0]);
    checkOutput("valid2", out_valid2, m_valid);
    checkOutput("pc2",    out_pc2,    m_pc);
    checkOutput("ir2",    out_ir2,    m_ir);
    checkOutput("data2",  out_data2,  m_data[W-1:0]);
    checkOutput("exc2",   out_exc2,   m_exc);
    checkOutput("bd2",    out_bd2,    m_bd);
    checkOutput("cnt2",   stall_cnt2, m_cnt2[1:0]);
  end

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic fl,
                               input logic fk, input logic v,
                               input logic [W-1:0] pc, input logic [W-1:0] ir,
                               input logic [W-1:0] lane0, input logic [4:0] ex,
                               input logic [4:0] exn, input logic bd);
    reset = rst; stall = st; flush = fl; flush_keep_pc = fk; in_valid = v;
    in_pc = pc; in_ir = ir; in_ctrl = ir ^ 32'h5A5A_5A5A;
    in_data = {pc ^ 32'hFFFF_0000, ~lane0, lane0};
    in_exc = ex; in_exc_new = exn; in_bd = bd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h3abc, 32'h1111, 32'h22, 5, 0, 1);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_pc", out_pc, 32'h3000);
    checkOutput("rst_cnt", stall_cnt, 0);

    applyStimulus(0, 0, 0, 0, 1, 32'h3004, 32'h8C01_0000, 32'h1234, 0, 0, 0);
    checkOutput("load_pc", out_pc, 32'h3004);
    checkOutput("load_ir", out_ir, 32'h8C01_0000);
    checkOutput("load_lane0", out_data[W-1:0], 32'h1234);
    checkOutput("load_valid", out_valid, 1);
    checkOutput("load_exc", out_exc, 0);

    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 0, 0, 0, 32'h4000 + i, 32'hDEAD_0000 + i, 32'h99 + i, 8, 10, 1);
    checkOutput("stall_pc", out_pc, 32'h3004);
    checkOutput("stall_lane0", out_data[W-1:0], 32'h1234);
    checkOutput("stall_cnt3", stall_cnt, 3);
    checkOutput("stall_cnt3_w2", stall_cnt2, 3);

    applyStimulus(0, 0, 0, 0, 1, 32'h3008, 32'h0000_0020, 32'h55, 0, 0, 0);
    checkOutput("release_pc", out_pc, 32'h3008);
    checkOutput("release_cnt", stall_cnt, 3);

    applyStimulus(0, 0, 0, 1, 1, 32'h3010, 32'hABCD_0000, 32'h66, 4, 0, 1);
    checkOutput("fkp_pc", out_pc, 32'h3010);
    checkOutput("fkp_bd", out_bd, 1);
    checkOutput("fkp_ir", out_ir, 0);
    checkOutput("fkp_valid", out_valid, 0);

    applyStimulus(0, 0, 1, 0, 1, 32'h3014, 32'hABCD_0000, 32'h66, 4, 0, 1);
    checkOutput("flush_pc", out_pc, 32'h3000);
    checkOutput("flush_bd", out_bd, 0);

    applyStimulus(0, 0, 0, 0, 1, 32'h3018, 32'h1, 32'h7, 4, 12, 0);
    checkOutput("exc_earliest", out_exc, 4);
    applyStimulus(0, 0, 0, 0, 1, 32'h301C, 32'h2, 32'h8, 0, 12, 0);
    checkOutput("exc_new", out_exc, 12);

    applyStimulus(0, 1, 1, 0, 1, 32'h3020, 32'h3, 32'h9, 0, 0, 1);
    checkOutput("stallflush_pc", out_pc, 32'h3000);
    checkOutput("stallflush_valid", out_valid, 0);
    checkOutput("stallflush_cnt", stall_cnt, 3);

    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 0, 0, 1, 32'h5000 + i, 32'h4, 32'hA, 0, 0, 0);
    checkOutput("sat_cnt_w2", stall_cnt2, 3);
    checkOutput("cnt9", stall_cnt, 9);

    applyStimulus(1, 1, 0, 0, 1, 32'h6000, 32'h5, 32'hB, 5, 5, 1);
    checkOutput("midrst_cnt", stall_cnt, 0);
    checkOutput("midrst_cnt_w2", stall_cnt2, 0);
    checkOutput("midrst_pc", out_pc, 32'h3000);

    applyStimulus(0, 0, 0, 0, 0, 32'h3024, 32'hCAFE_F00D, 32'h77, 0, 0, 1);
    checkOutput("invalid_ir", out_ir, 32'hCAFE_F00D);
    checkOutput("invalid_valid", out_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h3028, 32'h0, 32'h0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
